// File: rtl/uart_pkt_tx.sv
// rtl/uart_pkt_tx.sv - UART 8N1 transmitter for the 8-byte host config/status frame
//
// Sends HEAD, data_a, data_d, data_b[7:0], data_b[15:8], data_c[7:0], data_c[15:8], TAIL
// as UART 8N1, LSB first. One frame per pkt_valid/pkt_ready handshake.
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   synchronous active-low reset
//   pkt_valid  in   frame request; fields sampled on acceptance
//   pkt_ready  out  block idle and able to accept a frame
//   data_a     in   frame byte 1
//   data_d     in   frame byte 2
//   data_b     in   frame bytes 3 (low) and 4 (high)
//   data_c     in   frame bytes 5 (low) and 6 (high)
//   uart_txd   out  serial line, idle high, registered
//   tx_busy    out  high from acceptance to end of last stop bit
//   pkt_done   out  one-cycle pulse when the frame has completed
module uart_pkt_tx #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter logic [7:0]  HEAD_BYTE = 8'hAA,
    parameter logic [7:0]  TAIL_BYTE = 8'h55
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic [7:0]  data_a,
    input  logic [7:0]  data_d,
    input  logic [15:0] data_b,
    input  logic [15:0] data_c,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic        pkt_done
);

    localparam int unsigned BIT_CYC = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [63:0]      frame_q, frame_d;
    logic             txd_q, txd_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end;

    assign bit_end = (baud_cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        baud_cnt_d = baud_cnt_q;
        frame_d    = frame_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pkt_valid && ready_q) begin
                    state_d    = S_START;
                    byte_idx_d = 3'd0;
                    bit_idx_d  = 3'd0;
                    baud_cnt_d = '0;
                    busy_d     = 1'b1;
                    // Byte n of the frame lives at frame_q[8n +: 8], so the line bit is
                    // simply frame_q[{byte_idx, bit_idx}].
                    frame_d    = {TAIL_BYTE, data_c, data_b, data_d, data_a, HEAD_BYTE};
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (byte_idx_q == 3'd7) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = S_START;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Line level and ready are derived from the next state so both are registered
        // and change on the same edge as the state.
        ready_d = (state_d == S_IDLE);
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = frame_d[{byte_idx_d, bit_idx_d}];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            byte_idx_q <= 3'd0;
            bit_idx_q  <= 3'd0;
            baud_cnt_q <= '0;
            frame_q    <= '0;
            txd_q      <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            baud_cnt_q <= baud_cnt_d;
            frame_q    <= frame_d;
            txd_q      <= txd_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign uart_txd  = txd_q;
    assign pkt_ready = ready_q;
    assign tx_busy   = busy_q;
    assign pkt_done  = done_q;

endmodule

// File: tb/tb_uart_pkt_tx.sv
// tb/tb_uart_pkt_tx.sv - scoreboard bench for uart_pkt_tx with a cycle-exact UART decoder
module tb_uart_pkt_tx;

    // 1_000_000 / 75_000 truncates to 13 clocks per bit, keeping frames short.
    localparam int unsigned CLK_FREQ  = 1_000_000;
    localparam int unsigned BAUD_RATE = 75_000;
    localparam int BIT   = 13;
    localparam int FRAME = 80 * BIT;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        pkt_valid = 1'b0;
    logic [7:0]  data_a = 8'h00;
    logic [7:0]  data_d = 8'h00;
    logic [15:0] data_b = 16'h0000;
    logic [15:0] data_c = 16'h0000;
    logic        pkt_ready;
    logic        uart_txd;
    logic        tx_busy;
    logic        pkt_done;

    uart_pkt_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE),
        .HEAD_BYTE(8'hAA),
        .TAIL_BYTE(8'h55)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready),
        .data_a   (data_a),
        .data_d   (data_d),
        .data_b   (data_b),
        .data_c   (data_c),
        .uart_txd (uart_txd),
        .tx_busy  (tx_busy),
        .pkt_done (pkt_done)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    always @(posedge sys_clk) begin
        cyc = cyc + 1;
        if (pkt_done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic push_frame(input logic [7:0] a, input logic [7:0] d,
                              input logic [15:0] b, input logic [15:0] c);
        exp_q.push_back(8'hAA);
        exp_q.push_back(a);
        exp_q.push_back(d);
        exp_q.push_back(b[7:0]);
        exp_q.push_back(b[15:8]);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(8'h55);
    endtask

    // Returns at the negedge after the accepting edge (first start-bit sample).
    task automatic send(input logic [7:0] a, input logic [7:0] d,
                        input logic [15:0] b, input logic [15:0] c, input bit hold);
        int n;
        data_a = a; data_d = d; data_b = b; data_c = c;
        pkt_valid = 1'b1;
        push_frame(a, d, b, c);
        n = 0;
        while (pkt_ready !== 1'b1 && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        n_checks++;
        if (pkt_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: pkt_ready=%b, required 1 within 3000 cycles", pkt_ready);
            pkt_valid = 1'b0;
            return;
        end
        @(negedge sys_clk);
        if (!hold) pkt_valid = 1'b0;
        n_checks++;
        if (pkt_ready !== 1'b0 || tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL accept: pkt_ready=%b tx_busy=%b, required 0 1", pkt_ready, tx_busy);
        end
    endtask

    // Samples every cycle of all 80 bit slots; a slot that is not constant for exactly
    // BIT cycles, a wrong start/stop level or a wrong byte is reported.
    task automatic rx_frame(input string name, input bit drop_valid,
                            output int t_start, output int t_done);
        int         wait_n;
        int         bad_slot;
        int         bad_done;
        logic       v;
        logic [7:0] got;
        logic [7:0] exp;
        logic       frm_ok;
        t_start = 0;
        t_done  = 0;
        wait_n  = 0;
        while (uart_txd !== 1'b0 && wait_n < 4 * BIT) begin
            @(negedge sys_clk);
            wait_n++;
        end
        n_checks++;
        if (uart_txd !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start_wait: uart_txd=%b, required 0 within %0d cycles", name, uart_txd, 4 * BIT);
            for (int i = 0; i < 8; i++) if (exp_q.size() > 0) exp = exp_q.pop_front();
            return;
        end
        t_start = cyc;
        if (drop_valid) pkt_valid = 1'b0;
        bad_done = 0;
        for (int byt = 0; byt < 8; byt++) begin
            got = 8'h00;
            bad_slot = 0;
            frm_ok = 1'b1;
            for (int slot = 0; slot < 10; slot++) begin
                v = uart_txd;
                for (int k = 0; k < BIT; k++) begin
                    if (k > 0) @(negedge sys_clk);
                    if (uart_txd !== v) bad_slot++;
                    if (pkt_done !== 1'b0) bad_done++;
                    if (tx_busy !== 1'b1) bad_done++;
                end
                if (slot == 0 && v !== 1'b0) frm_ok = 1'b0;
                if (slot == 9 && v !== 1'b1) frm_ok = 1'b0;
                if (slot >= 1 && slot <= 8) got[slot-1] = v;
                @(negedge sys_clk);
            end
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s byte%0d: got %02h, required %02h", name, byt, got, exp);
            end
            n_checks++;
            if (bad_slot != 0) begin
                n_fail++;
                $display("FAIL %s timing%0d: %0d off-grid samples, required 0", name, byt, bad_slot);
            end
            n_checks++;
            if (!frm_ok) begin
                n_fail++;
                $display("FAIL %s framing%0d: start/stop level wrong, required start 0 stop 1", name, byt);
            end
        end
        t_done = cyc;
        n_checks++;
        if (bad_done != 0) begin
            n_fail++;
            $display("FAIL %s in_frame_flags: %0d samples with pkt_done!=0 or tx_busy!=1, required 0", name, bad_done);
        end
        n_checks++;
        if (pkt_done !== 1'b1 || tx_busy !== 1'b0 || pkt_ready !== 1'b1 || uart_txd !== 1'b1) begin
            n_fail++;
            $display("FAIL %s end_flags: done=%b busy=%b ready=%b txd=%b, required 1 0 1 1",
                     name, pkt_done, tx_busy, pkt_ready, uart_txd);
        end
        n_checks++;
        if (t_done - t_start != FRAME) begin
            n_fail++;
            $display("FAIL %s frame_len: %0d clocks, required %0d", name, t_done - t_start, FRAME);
        end
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        sys_rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            if (uart_txd !== 1'b1 || pkt_ready !== 1'b0 || tx_busy !== 1'b0 || pkt_done !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_levels: %0d bad samples (txd=%b ready=%b busy=%b done=%b), required txd1 ready0 busy0 done0",
                     bad, uart_txd, pkt_ready, tx_busy, pkt_done);
        end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        n_checks++;
        if (pkt_ready !== 1'b1 || uart_txd !== 1'b1 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b txd=%b busy=%b, required 1 1 0", pkt_ready, uart_txd, tx_busy);
        end
    endtask

    task automatic test_single_frame();
        int ts, td, dc;
        dc = done_cnt;
        send(8'h08, 8'h00, 16'h0000, 16'h0000, 1'b0);
        rx_frame("single", 1'b0, ts, td);
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if (done_cnt - dc != 1) begin
            n_fail++;
            $display("FAIL single_done_count: %0d pulses, required 1", done_cnt - dc);
        end
    endtask

    task automatic test_bit_timing();
        int ts, td;
        send(8'h55, 8'hAA, 16'h00FF, 16'hF00F, 1'b0);
        rx_frame("timing", 1'b0, ts, td);
    endtask

    task automatic test_field_order();
        int ts, td;
        send(8'h5A, 8'hC3, 16'h1234, 16'hABCD, 1'b0);
        rx_frame("order", 1'b0, ts, td);
        for (int i = 0; i < 2; i++) begin
            send(8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), 1'b0);
            rx_frame("random", 1'b0, ts, td);
        end
    endtask

    task automatic test_back_to_back();
        int ts1, td1, ts2, td2, dc;
        repeat (4) @(negedge sys_clk);
        dc = done_cnt;
        send(8'h11, 8'h22, 16'h3344, 16'h5566, 1'b1);
        data_a = 8'h99; data_d = 8'h88; data_b = 16'h7766; data_c = 16'h5544;
        push_frame(8'h99, 8'h88, 16'h7766, 16'h5544);
        rx_frame("b2b_first", 1'b0, ts1, td1);
        rx_frame("b2b_second", 1'b1, ts2, td2);
        n_checks++;
        if (ts2 != td1 + 1) begin
            n_fail++;
            $display("FAIL b2b_gap: second start at %0d, required %0d", ts2, td1 + 1);
        end
        repeat (3 * BIT) @(negedge sys_clk);
        n_checks++;
        if (done_cnt - dc != 2 || uart_txd !== 1'b1 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_count: %0d pulses txd=%b busy=%b, required 2 1 0", done_cnt - dc, uart_txd, tx_busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int ts, td, dc;
        send(8'hDE, 8'hAD, 16'hBEEF, 16'hCAFE, 1'b0);
        repeat (34 * BIT) @(negedge sys_clk);
        exp_q.delete();
        dc = done_cnt;
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        n_checks++;
        if (uart_txd !== 1'b1 || pkt_ready !== 1'b0 || tx_busy !== 1'b0 || pkt_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_levels: txd=%b ready=%b busy=%b done=%b, required 1 0 0 0",
                     uart_txd, pkt_ready, tx_busy, pkt_done);
        end
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2 * BIT) @(negedge sys_clk);
        n_checks++;
        if (done_cnt != dc || uart_txd !== 1'b1 || pkt_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_idle: %0d pulses txd=%b ready=%b, required 0 1 1", done_cnt - dc, uart_txd, pkt_ready);
        end
        send(8'h3C, 8'hA5, 16'h0F0F, 16'h8001, 1'b0);
        rx_frame("after_reset", 1'b0, ts, td);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_bit_timing();
        test_field_order();
        test_back_to_back();
        test_reset_mid_frame();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d bytes left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
